// File: rtl/instr_queue.sv
// Fetch-to-decode decoupling FIFO: holds {instruction, pc, fetch_err} entries
// until decode accepts them; a flush discards everything in one clock.
module instr_queue #(
  parameter int DEPTH = 4,
  parameter int ILEN  = 32,
  parameter int XLEN  = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [ILEN-1:0]            instruction_i,
  input  logic [XLEN-1:0]            pc_i,
  input  logic                       fetch_err_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [ILEN-1:0]            instruction_o,
  output logic [XLEN-1:0]            pc_o,
  output logic                       fetch_err_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [ILEN-1:0] instr_q [DEPTH];
  logic [XLEN-1:0] pc_q    [DEPTH];
  logic [DEPTH-1:0] err_q;

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push, pop;

  // Status depends only on registered occupancy, so ready_o never sees ready_i.
  assign ready_o       = (cnt_q != FULL);
  assign valid_o       = (cnt_q != '0);
  assign push          = valid_i & ready_o;
  assign pop           = valid_o & ready_i;
  assign instruction_o = instr_q[rd_ptr_q];
  assign pc_o          = pc_q[rd_ptr_q];
  assign fetch_err_o   = err_q[rd_ptr_q];
  assign count_o       = cnt_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      cnt_d = cnt_q + CW'(1);
      else if (pop && !push) cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage is never reset; a push coinciding with reset or flush is dropped.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i && push) begin
      instr_q[wr_ptr_q] <= instruction_i;
      pc_q[wr_ptr_q]    <= pc_i;
      err_q[wr_ptr_q]   <= fetch_err_i;
    end
  end

endmodule

// File: doc/instr_queue.md
Name: instr_queue

Overview:
- Fetch-to-decode decoupling FIFO. Sits directly downstream of the fetch instruction selector.
- Captures each selected instruction together with its full PC and holds it until the decode stage accepts it.
- Absorbs decode stalls and cache refill bubbles. Discards all contents on a pipeline flush (branch mispredict or exception redirect).

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- ILEN, ILEN from mmm_pkg (32), instruction width.
- XLEN, XLEN from mmm_pkg (32), PC width.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous reset, active-high.
- flush_i  input  1  discard all entries this cycle.
- valid_i  input  1  fetch presents a valid instruction.
- ready_o  output  1  queue can accept an entry.
- instruction_i  input  ILEN  instruction from the fetch selector.
- pc_i  input  XLEN  PC of instruction_i.
- fetch_err_i  input  1  fetch fault flag travelling with the entry.
- valid_o  output  1  head entry is valid.
- ready_i  input  1  decode accepts the head entry.
- instruction_o  output  ILEN  head instruction.
- pc_o  output  XLEN  head PC.
- fetch_err_o  output  1  head fault flag.
- count_o  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage:
  - Circular buffer of DEPTH entries {instruction, pc, fetch_err}.
  - Read pointer (rd_ptr) and write pointer (wr_ptr), each $clog2(DEPTH) bits, wrap naturally modulo DEPTH.
  - Occupancy counter cnt, $clog2(DEPTH)+1 bits.
- Events:
  - push = valid_i & ready_o.
  - pop = valid_o & ready_i.
- Status outputs:
  - ready_o = (cnt != DEPTH). Depends only on registered state; no combinational path from ready_i.
  - valid_o = (cnt != 0). instruction_o, pc_o and fetch_err_o are read combinationally from entry rd_ptr.
  - count_o = cnt.
- Latency:
  - An entry pushed in cycle N is visible on valid_o in cycle N+1.
  - There is no empty-queue bypass.
- Update rules, evaluated in priority order each clock:
  1. rst_i=1: rd_ptr=0, wr_ptr=0, cnt=0. Entry storage is not reset.
  2. flush_i=1: rd_ptr=0, wr_ptr=0, cnt=0. Any simultaneous push and pop are ignored; the pushed entry is dropped.
  3. Otherwise:
     - push: write the entry at wr_ptr, wr_ptr+1.
     - pop: rd_ptr+1.
     - cnt: +1 on push only, -1 on pop only, unchanged on push & pop.
- Outputs after reset: valid_o=0, ready_o=1, count_o=0. instruction_o, pc_o and fetch_err_o are don't-care while valid_o=0.
- Boundary conditions:
  - Full (cnt=DEPTH): ready_o=0, so no push occurs. A pop in this cycle makes ready_o=1 in the next cycle; there is no same-cycle full pass-through.
  - Empty: valid_o=0, so no pop occurs. A push while empty does not produce valid_o in the same cycle.
  - Simultaneous push and pop at cnt between 1 and DEPTH-1: cnt unchanged, both pointers advance.
  - Pointer wrap: wr_ptr and rd_ptr move DEPTH-1 -> 0 with no special handling.
  - valid_i while ready_o=0: the input is ignored. Fetch holds its data; the queue imposes no stability requirement.
  - Reset or flush mid-stream: takes effect in the clock it is sampled. The next cycle shows valid_o=0, count_o=0.
- Handshake:
  - Stable outputs: once valid_o=1, the head entry does not change until popped or flushed.
  - Assertions (bench): no push when cnt=DEPTH; no pop when cnt=0; cnt always equals (wr_ptr - rd_ptr) mod 2·DEPTH when tracked with an extra wrap bit.

Test Plan:
1. Reset then idle:
   - Stimulus: rst_i=1 for 2 cycles, then release.
   - Response: valid_o=0, ready_o=1, count_o=0. Outputs hold across 5 idle cycles.
2. Fill and drain, DEPTH=4:
   - Stimulus: push pc 0x100, 0x104, 0x108, 0x10C with instructions 0xA0..0xA3, ready_i=0.
   - Response: count_o=4, ready_o=0. A 5th valid_i (pc 0x110) is ignored.
   - Then ready_i=1: pops in order 0x100..0x10C, count_o reaches 0, valid_o=0.
3. Streaming:
   - Stimulus: valid_i=1 and ready_i=1 continuously for 12 cycles, pc incrementing by 4.
   - Response: count_o settles at 1. Outputs follow inputs with 1-cycle latency, no gaps. Pointers wrap 3 times.
4. Full with simultaneous pop:
   - Stimulus: at count_o=4, assert ready_i=1 and valid_i=1.
   - Response: pop only; count_o=3 and ready_o=1 in the next cycle.
5. Flush during push and pop:
   - Stimulus: at count_o=2, flush_i=1 together with valid_i=1 and ready_i=1.
   - Response: next cycle count_o=0, valid_o=0. The pushed entry never appears. The subsequent push of pc 0x200 emerges first.
6. Error flag and mid-stream reset:
   - Stimulus: push pc 0x300 with fetch_err_i=1.
   - Response: head shows fetch_err_o=1, pc_o=0x300.
   - Then rst_i=1 with 3 entries held: next cycle count_o=0, ready_o=1.
